stopwatch_lap_timer: RTL and testbench

- Parametrised BCD MM:SS stopwatch/timer for board-level timing.
- Count-up (stopwatch) and count-down (preset timer) modes, lap capture, terminal-count done pulse.
- Exact-period prescaler from system clock.
- Drives the 4-digit 7-seg display path; done feeds buzzer/LED logic.

---
 rtl/stopwatch_pkg.sv | 63 ++++++
 rtl/sw_prescaler.sv | 34 +++
 rtl/stopwatch_lap_timer.sv | 154 +++++++++++++++
 tb/tb_stopwatch_lap_timer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the MM:SS stopwatch/timer.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  // Display order {m1,m0,s1,s0}, matching the 16-bit preset and lap buses.
  typedef struct packed {
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } time_t;

  // One digit step: new digit value plus carry (up) or borrow (down) out.
  typedef struct packed {
    bcd_t digit;
    logic carry;
  } bcd_step_t;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t S1_MAX    = 4'd5;

  // Increment a digit that counts 0..max, carrying out on wrap.
  function automatic bcd_step_t bcd_inc(input bcd_t d, input bcd_t max);
    bcd_step_t r;
    if (d >= max) begin
      r.digit = '0;
      r.carry = 1'b1;
    end else begin
      r.digit = d + 4'd1;
      r.carry = 1'b0;
    end
    return r;
  endfunction

  // Decrement a digit that counts max..0, borrowing out on wrap.
  function automatic bcd_step_t bcd_dec(input bcd_t d, input bcd_t max);
    bcd_step_t r;
    if (d == '0) begin
      r.digit = max;
      r.carry = 1'b1;
    end else begin
      r.digit = d - 4'd1;
      r.carry = 1'b0;
    end
    return r;
  endfunction

  function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max);
    return (d > max) ? max : d;
  endfunction

  // Force each preset digit into its legal range so the chain never sees bad BCD.
  function automatic time_t clamp_preset(input time_t p, input bcd_t m1_max);
    time_t r;
    r.m1 = clamp_digit(p.m1, m1_max);
    r.m0 = clamp_digit(p.m0, DIGIT_MAX);
    r.s1 = clamp_digit(p.s1, S1_MAX);
    r.s0 = clamp_digit(p.s0, DIGIT_MAX);
    return r;
  endfunction

endpackage

// File: rtl/sw_prescaler.sv
// Exact-period divider: one tick every TICKS_PER_SEC enabled cycles.
// The count holds while disabled so a partially elapsed second resumes.
module sw_prescaler #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int PRESC_W       = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] cnt;

  // Divider count: clear wins, otherwise advance and wrap while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PRESC_W'(1);
    end
  end

  // A clear in the wrap cycle cancels that second.
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/stopwatch_lap_timer.sv
// BCD MM:SS stopwatch / countdown timer with lap capture and done pulse.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int PRESC_W       = 27,
  parameter int M1_MAX        = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic        mode_down,
  input  logic [15:0] preset,
  input  logic        lap,
  output logic [3:0]  s0,
  output logic [3:0]  s1,
  output logic [3:0]  m0,
  output logic [3:0]  m1,
  output logic [15:0] lap_time,
  output logic        lap_valid,
  output logic        running,
  output logic        sec_tick,
  output logic        done
);

  localparam bcd_t  M1_LIM = bcd_t'(M1_MAX);
  localparam time_t T_UP   = {M1_LIM, DIGIT_MAX, S1_MAX, DIGIT_MAX};

  time_t     cur_q;
  time_t     nxt;
  time_t     lap_q;
  logic      run_q;
  logic      mode_q;
  logic      done_q;
  logic      lap_valid_q;
  logic      tick;
  logic      load_ok;
  logic      reach_term;
  logic      start_blocked;
  bcd_step_t step0, step1, step2, step3;

  // Load only takes effect while stopped; it also restarts the partial second.
  assign load_ok = load && !run_q;

  sw_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .PRESC_W      (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (run_q),
    .clr    (clear || load_ok),
    .tick   (tick)
  );

  // Next time value for one counted second: ripple carry/borrow up the digits.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    step0 = mode_q ? bcd_dec(cur_q.s0, DIGIT_MAX) : bcd_inc(cur_q.s0, DIGIT_MAX);
    step1 = mode_q ? bcd_dec(cur_q.s1, S1_MAX)    : bcd_inc(cur_q.s1, S1_MAX);
    step2 = mode_q ? bcd_dec(cur_q.m0, DIGIT_MAX) : bcd_inc(cur_q.m0, DIGIT_MAX);
    step3 = mode_q ? bcd_dec(cur_q.m1, M1_LIM)    : bcd_inc(cur_q.m1, M1_LIM);
    nxt    = cur_q;
    nxt.s0 = step0.digit;
    if (step0.carry) begin
      nxt.s1 = step1.digit;
      if (step1.carry) begin
        nxt.m0 = step2.digit;
        if (step2.carry) begin
          nxt.m1 = step3.digit;
          // Carry out of the top digit would be a wrap; hold instead.
          if (step3.carry) nxt = cur_q;
        end
      end
    end
  end

  // Terminal value for the direction being counted / about to be counted.
  assign reach_term    = mode_q    ? (nxt == '0)   : (nxt == T_UP);
  assign start_blocked = mode_down ? (cur_q == '0) : (cur_q == T_UP);

  // Live time register: clear > load > per-second update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q <= '0;
    end else if (clear) begin
      cur_q <= '0;
    end else if (load_ok) begin
      cur_q <= clamp_preset(time_t'(preset), M1_LIM);
    end else if (tick) begin
      cur_q <= nxt;
    end
  end

  // Run flag and terminal-count pulse; terminal stop overrides start/stop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        run_q <= 1'b0;
      end else if (!load_ok) begin
        if (tick && reach_term) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else if (start && !stop && !start_blocked) begin
          run_q <= 1'b1;
        end else if (stop && !start) begin
          run_q <= 1'b0;
        end
      end
    end
  end

  // Direction is latched only while stopped so a run never changes direction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
    end else if (!run_q) begin
      mode_q <= mode_down;
    end
  end

  // Lap capture of the pre-update time; clear wipes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
    end else if (clear) begin
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
    end else if (lap) begin
      lap_q       <= cur_q;
      lap_valid_q <= 1'b1;
    end
  end

  assign s0        = cur_q.s0;
  assign s1        = cur_q.s1;
  assign m0        = cur_q.m0;
  assign m1        = cur_q.m1;
  assign lap_time  = lap_q;
  assign lap_valid = lap_valid_q;
  assign running   = run_q;
  assign sec_tick  = tick;
  assign done      = done_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Self-checking bench: seconds-based reference model compared every cycle,
// plus directed literal expectations along the stimulus sequence.
module tb_stopwatch_lap_timer;

  localparam int TPS      = 4;
  localparam int PW       = 3;
  localparam int M1M      = 9;
  localparam int MAX_SECS = (M1M * 10 + 9) * 60 + 59;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
  logic        mode_down = 1'b0, lap = 1'b0;
  logic [15:0] preset = '0;
  logic [3:0]  s0, s1, m0, m1;
  logic [15:0] lap_time;
  logic        lap_valid, running, sec_tick, done;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;

  // Reference model state: time and lap kept as plain seconds.
  int m_secs, m_cnt, m_lap;
  bit m_lv, m_run, m_mode, m_done;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(
    .TICKS_PER_SEC(TPS),
    .PRESC_W      (PW),
    .M1_MAX       (M1M)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .mode_down(mode_down),
    .preset   (preset),
    .lap      (lap),
    .s0       (s0),
    .s1       (s1),
    .m0       (m0),
    .m1       (m1),
    .lap_time (lap_time),
    .lap_valid(lap_valid),
    .running  (running),
    .sec_tick (sec_tick),
    .done     (done)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int preset_secs(input logic [15:0] p);
    int d3, d2, d1, d0;
    d3 = int'(p[15:12]); if (d3 > M1M) d3 = M1M;
    d2 = int'(p[11:8]);  if (d2 > 9)   d2 = 9;
    d1 = int'(p[7:4]);   if (d1 > 5)   d1 = 5;
    d0 = int'(p[3:0]);   if (d0 > 9)   d0 = 9;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  // Reference model, stepped on each active edge from pre-edge inputs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_secs = 0; m_cnt = 0; m_lap = 0;
      m_lv = 0; m_run = 0; m_mode = 0; m_done = 0;
    end else begin : step
      bit m_tick, blocked, old_run;
      int old_secs;
      old_secs = m_secs;
      old_run  = m_run;
      m_tick   = m_run && (m_cnt == TPS - 1) && !clear;
      blocked  = mode_down ? (old_secs == 0) : (old_secs == MAX_SECS);
      m_done   = 0;
      if (clear) begin
        m_secs = 0; m_cnt = 0; m_lap = 0; m_lv = 0; m_run = 0;
      end else begin
        if (load && !old_run) begin
          m_secs = preset_secs(preset);
          m_cnt  = 0;
        end else begin
          if (old_run) m_cnt = (m_cnt + 1) % TPS;
          if (m_tick) m_secs = m_mode ? old_secs - 1 : old_secs + 1;
          if (m_tick && (m_mode ? (m_secs == 0) : (m_secs == MAX_SECS))) begin
            m_run  = 0;
            m_done = 1;
          end else if (start && !stop && !blocked) begin
            m_run = 1;
          end else if (stop && !start) begin
            m_run = 0;
          end
        end
        if (lap) begin
          m_lap = old_secs;
          m_lv  = 1;
        end
      end
      if (!old_run) m_mode = mode_down;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("time",      {m1, m0, s1, s0}, to_bcd(m_secs));
    check("lap_time",  lap_time, to_bcd(m_lap));
    check("lap_valid", 16'(lap_valid), 16'(m_lv));
    check("running",   16'(running), 16'(m_run));
    check("sec_tick",  16'(sec_tick), 16'(m_run && (m_cnt == TPS - 1) && !clear));
    check("done",      16'(done), 16'(m_done));
    if (sec_tick === 1'b1) ticks_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] p);
    preset = p; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  initial begin
    cyc(3);
    reset_n = 1'b1;
    check("rst_time", {m1, m0, s1, s0}, 16'h0000);
    check("rst_running", 16'(running), 16'd0);

    // Count up 10 seconds, then stop mid-second and resume.
    mode_down = 1'b0;
    ticks_seen = 0;
    pulse_start();
    cyc(40);
    check("up_10s", {m1, m0, s1, s0}, 16'h0010);
    check("up_ticks", 16'(ticks_seen), 16'd10);
    cyc(2);
    pulse_stop();
    cyc(20);
    check("hold_time", {m1, m0, s1, s0}, 16'h0010);
    check("hold_ticks", 16'(ticks_seen), 16'd10);
    pulse_start();
    check("resume_tick", 16'(sec_tick), 16'd1);
    cyc(1);
    check("resume_time", {m1, m0, s1, s0}, 16'h0011);
    pulse_stop();

    // Carry chain and up terminal count.
    do_load(16'h0959);
    check("load_0959", {m1, m0, s1, s0}, 16'h0959);
    pulse_start();
    cyc(4);
    check("carry_1000", {m1, m0, s1, s0}, 16'h1000);
    pulse_stop();
    do_load(16'h9958);
    pulse_start();
    cyc(4);
    check("up_term", {m1, m0, s1, s0}, 16'h9959);
    check("up_done", 16'(done), 16'd1);
    check("up_stopped", 16'(running), 16'd0);
    cyc(1);
    check("up_done_pulse", 16'(done), 16'd0);
    pulse_start();
    check("up_start_ignored", 16'(running), 16'd0);
    cyc(4);
    check("up_no_wrap", {m1, m0, s1, s0}, 16'h9959);

    // Count down, borrow and down terminal count.
    mode_down = 1'b1;
    do_load(16'h0100);
    pulse_start();
    cyc(4);
    check("borrow_0059", {m1, m0, s1, s0}, 16'h0059);
    pulse_stop();
    do_load(16'h0002);
    pulse_start();
    cyc(8);
    check("down_term", {m1, m0, s1, s0}, 16'h0000);
    check("down_done", 16'(done), 16'd1);
    check("down_stopped", 16'(running), 16'd0);
    pulse_start();
    check("down_start_ignored", 16'(running), 16'd0);

    // Preset clamp and run-time guards on load and direction.
    mode_down = 1'b0;
    do_load(16'hFA7C);
    check("clamp", {m1, m0, s1, s0}, 16'h9959);
    do_load(16'h0030);
    pulse_start();
    cyc(2);
    mode_down = 1'b1;
    preset = 16'h0500;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
    check("guard_time", {m1, m0, s1, s0}, 16'h0031);
    check("guard_running", 16'(running), 16'd1);
    mode_down = 1'b0;
    pulse_stop();

    // Lap on a tick cycle, start/stop collision, clear over load.
    clear = 1'b1; cyc(1); clear = 1'b0;
    check("clear_time", {m1, m0, s1, s0}, 16'h0000);
    pulse_start();
    cyc(23);
    lap = 1'b1; cyc(1); lap = 1'b0;
    check("lap_capture", lap_time, 16'h0005);
    check("lap_live", {m1, m0, s1, s0}, 16'h0006);
    check("lap_valid", 16'(lap_valid), 16'd1);
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    check("both_running", 16'(running), 16'd1);
    pulse_stop();
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    check("both_stopped", 16'(running), 16'd0);
    preset = 16'h1234;
    clear = 1'b1; load = 1'b1; cyc(1); clear = 1'b0; load = 1'b0;
    check("clrload_time", {m1, m0, s1, s0}, 16'h0000);
    check("clrload_lap", lap_time, 16'h0000);
    check("clrload_valid", 16'(lap_valid), 16'd0);

    // Asynchronous reset mid-count, then prescaler restarts from zero.
    lap = 1'b1; cyc(1); lap = 1'b0;
    pulse_start();
    cyc(30);
    check("pre_reset_time", {m1, m0, s1, s0}, 16'h0007);
    reset_n = 1'b0;
    #1;
    check("arst_time", {m1, m0, s1, s0}, 16'h0000);
    check("arst_running", 16'(running), 16'd0);
    check("arst_lap_valid", 16'(lap_valid), 16'd0);
    check("arst_sec_tick", 16'(sec_tick), 16'd0);
    cyc(2);
    reset_n = 1'b1;
    pulse_start();
    cyc(3);
    check("post_reset_3", {m1, m0, s1, s0}, 16'h0000);
    cyc(1);
    check("post_reset_4", {m1, m0, s1, s0}, 16'h0001);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
